serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
Multi-cycle parametrised adder. A single DIGIT-bit full-adder slice and a carry register process WIDTH-bit operands LSB-first over WIDTH/DIGIT cycles, with a start/busy/done handshake. Successor to the one-bit combinational full adder. Used wherever area matters more than latency, for example in accumulators and checksum units.

Parameters:
WIDTH, 8, operand and sum width in bits; >= 2
DIGIT, 1, bits processed per cycle; must divide WIDTH; DIGIT == WIDTH gives a single-cycle add
N (localparam), WIDTH/DIGIT, cycles per operation

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
a  input  WIDTH  operand A; sampled on accepted start
b  input  WIDTH  operand B; sampled on accepted start
cin  input  1  carry-in; sampled on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  registered result
cout  output  1  registered carry-out of MSB
ovf  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst high at an edge): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal registers cleared. Reset overrides everything, including mid-RUN; the in-flight operation is discarded and no done is produced.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE: an edge with start=1 latches a, b, cin into operand shift registers and the carry register, clears the digit counter, and moves to RUN. start=0 stays in IDLE.
- RUN: each edge adds the low DIGIT bits of both shift registers plus the carry, shifts the DIGIT sum bits into the result register from the top, updates carry, shifts operands right by DIGIT, and increments the counter.
- RUN exit: after the N-th digit edge, move to DONE. On that same edge, load sum, cout and ovf. ovf uses the carry into bit WIDTH-1, which is tracked inside the final digit.
- DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: start accepted at edge k; done=1 in the cycle after edge k+N; sum/cout/ovf valid from that cycle.
- Throughput: one operation per N+2 cycles. start in RUN or DONE is ignored; it is not queued.
- busy=1 exactly in RUN. done=1 exactly in DONE. The two are never high together.
- sum/cout/ovf change only on the edge entering DONE and hold until the next completion or reset. Operand inputs may change freely after the accepting edge.
- Arithmetic is modulo 2^WIDTH; cout carries bit WIDTH.
- Counter width is clog2(N+1); it must not wrap inside RUN.

Optional Feature:
Macro SERIAL_ADDER_SUB_EN.
- Defined: an extra input port sub (1 bit), sampled with start. sub=1 loads ~b and forces carry-in to 1, ignoring cin, so the result is a-b. cout=1 means no borrow; ovf is signed-subtract overflow.
- Undefined: no sub port; always add.

Test Plan:
- WIDTH=8, DIGIT=1: a=0x00, b=0x00, cin=0, start at edge k -> busy for 8 cycles; done at cycle after k+8; sum=0x00, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1. a=0x80, b=0x80, cin=1 -> sum=0x01, cout=1, ovf=1.
- start for 0x10+0x20, then start held high with a=0xAA, b=0x55 through RUN and DONE -> first result sum=0x30; second op accepted only in IDLE, then sum=0xFF, cout=0.
- rst asserted at RUN cycle 4 of a 0x3C+0x0F add -> next cycle all outputs 0, no done pulse; a fresh 0x01+0x01 then gives sum=0x02.
- WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001, cin=1 -> done 4 cycles after acceptance; sum=0x0001, cout=1. WIDTH=8, DIGIT=8: done 1 cycle after acceptance.
- SERIAL_ADDER_SUB_EN defined, WIDTH=8: sub=1, a=0x05, b=0x07, cin=1 -> sum=0xFE, cout=0, ovf=0. sub=1, a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.

Source files
------------

// File: rtl/serial_adder.sv
// Multi-cycle adder: one DIGIT-bit ripple slice walks WIDTH-bit operands LSB-first.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input that turns the operation into a-b.
module serial_adder #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] opa, opb, res, res_nxt, dsum_w, b_ld;
   logic [DIGIT-1:0] dsum;
   logic             carry, c, c_msb, c_ld, last;
   logic [CW-1:0]    cnt;

`ifdef SERIAL_ADDER_SUB_EN
   assign b_ld = sub ? ~b : b;
   assign c_ld = sub | cin;
`else
   assign b_ld = b;
   assign c_ld = cin;
`endif

   assign last = (cnt == LAST);
   assign busy = (state == RUN);
   assign done = (state == DONE);

   // Digit slice; c_msb is the carry into the slice's top bit, which on the
   // final digit is the carry into bit WIDTH-1 needed for overflow.
   always_comb begin
      c      = carry;
      c_msb  = carry;
      dsum   = '0;
      for (int i = 0; i < DIGIT; i++) begin
         if (i == DIGIT - 1) c_msb = c;
         dsum[i] = opa[i] ^ opb[i] ^ c;
         c       = (opa[i] & opb[i]) | (c & (opa[i] ^ opb[i]));
      end
      dsum_w              = '0;
      dsum_w[DIGIT-1:0]   = dsum;
      res_nxt             = (res >> DIGIT) | (dsum_w << (WIDTH - DIGIT));
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opa   <= '0;
         opb   <= '0;
         res   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               opa   <= a;
               opb   <= b_ld;
               carry <= c_ld;
               cnt   <= '0;
               res   <= '0;
            end
            RUN: begin
               opa   <= opa >> DIGIT;
               opb   <= opb >> DIGIT;
               carry <= c;
               res   <= res_nxt;
               cnt   <= cnt + CW'(1);
               // Outputs only move on the edge entering DONE.
               if (last) begin
                  sum  <= res_nxt;
                  cout <= c;
                  ovf  <= c_msb ^ c;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: 8/1 (main), 16/4 and 8/8 instances.
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

   logic clk, rst;
   int   tests_run = 0, tests_failed = 0;

   logic       start0, cin0, sub0;
   logic [7:0] a0, b0, sum0;
   logic       busy0, done0, cout0, ovf0;

   logic        start1, cin1;
   logic [15:0] a1, b1, sum1;
   logic        busy1, done1, cout1, ovf1;

   logic       start2, cin2;
   logic [7:0] a2, b2, sum2;
   logic       busy2, done2, cout2, ovf2;

   serial_adder #(.WIDTH(8), .DIGIT(1)) dut0 (
      .clk(clk), .rst(rst), .start(start0),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub0),
`endif
      .a(a0), .b(b0), .cin(cin0), .busy(busy0), .done(done0),
      .sum(sum0), .cout(cout0), .ovf(ovf0));

   serial_adder #(.WIDTH(16), .DIGIT(4)) dut1 (
      .clk(clk), .rst(rst), .start(start1),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(1'b0),
`endif
      .a(a1), .b(b1), .cin(cin1), .busy(busy1), .done(done1),
      .sum(sum1), .cout(cout1), .ovf(ovf1));

   serial_adder #(.WIDTH(8), .DIGIT(8)) dut2 (
      .clk(clk), .rst(rst), .start(start2),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(1'b0),
`endif
      .a(a2), .b(b2), .cin(cin2), .busy(busy2), .done(done2),
      .sum(sum2), .cout(cout2), .ovf(ovf2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drivers only: start for one edge, then count negedges up to and including done.
   task automatic drv8(input logic [7:0] ta, tb, input logic tc, ts,
                       output int lat, output int bsy, output logic both);
      @(negedge clk); a0 = ta; b0 = tb; cin0 = tc; sub0 = ts; start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      lat = 0; bsy = 0; both = 1'b0;
      while (1) begin
         lat++;
         if (busy0) bsy++;
         if (busy0 && done0) both = 1'b1;
         if (done0 || lat >= 40) break;
         @(negedge clk);
      end
   endtask

   task automatic drv16(input logic [15:0] ta, tb, input logic tc, output int lat);
      @(negedge clk); a1 = ta; b1 = tb; cin1 = tc; start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      lat = 1;
      while (!done1 && lat < 40) begin @(negedge clk); lat++; end
   endtask

   task automatic drv88(input logic [7:0] ta, tb, input logic tc, output int lat);
      @(negedge clk); a2 = ta; b2 = tb; cin2 = tc; start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
      lat = 1;
      while (!done2 && lat < 40) begin @(negedge clk); lat++; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      tests_run++; if ({busy0, done0, sum0, cout0, ovf0} !== 12'h0) begin tests_failed++; $display("FAIL reset_dut0 got %h exp 000", {busy0, done0, sum0, cout0, ovf0}); end
      tests_run++; if ({busy1, done1, sum1, cout1, ovf1} !== 20'h0) begin tests_failed++; $display("FAIL reset_dut1 got %h exp 00000", {busy1, done1, sum1, cout1, ovf1}); end
      tests_run++; if ({busy2, done2, sum2, cout2, ovf2} !== 12'h0) begin tests_failed++; $display("FAIL reset_dut2 got %h exp 000", {busy2, done2, sum2, cout2, ovf2}); end
      rst = 1'b0;
      @(negedge clk);
      tests_run++; if ({busy0, done0} !== 2'b00) begin tests_failed++; $display("FAIL idle_no_start got %b exp 00", {busy0, done0}); end
   endtask

   task automatic test_add_vectors();
      logic [7:0] va [5] = '{8'h00, 8'hFF, 8'h7F, 8'h80, 8'h5A};
      logic [7:0] vb [5] = '{8'h00, 8'h01, 8'h01, 8'h80, 8'h3C};
      logic       vc [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [9:0] ex [5] = '{{8'h00, 1'b0, 1'b0}, {8'h00, 1'b1, 1'b0}, {8'h80, 1'b0, 1'b1},
                             {8'h01, 1'b1, 1'b1}, {8'h97, 1'b0, 1'b1}};
      int lat, bsy; logic both;
      for (int i = 0; i < 5; i++) begin
         drv8(va[i], vb[i], vc[i], 1'b0, lat, bsy, both);
         tests_run++; if ({sum0, cout0, ovf0} !== ex[i]) begin tests_failed++; $display("FAIL add%0d result got %h exp %h", i, {sum0, cout0, ovf0}, ex[i]); end
         tests_run++; if (lat !== 9 || bsy !== 8 || both !== 1'b0) begin tests_failed++; $display("FAIL add%0d timing lat %0d busy %0d both %b exp 9 8 0", i, lat, bsy, both); end
         @(negedge clk);
         tests_run++; if ({busy0, done0} !== 2'b00) begin tests_failed++; $display("FAIL add%0d done_pulse got %b exp 00", i, {busy0, done0}); end
      end
   endtask

   task automatic test_back_to_back();
      int n; logic held_ok;
      @(negedge clk); a0 = 8'h10; b0 = 8'h20; cin0 = 1'b0; sub0 = 1'b0; start0 = 1'b1;
      @(negedge clk); a0 = 8'hAA; b0 = 8'h55;
      n = 1;
      while (!done0 && n < 40) begin @(negedge clk); n++; end
      tests_run++; if (sum0 !== 8'h30 || n !== 9) begin tests_failed++; $display("FAIL b2b_first sum %h lat %0d exp 30 9", sum0, n); end
      @(negedge clk);
      tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL b2b_done_ignores_start busy %b exp 0", busy0); end
      n = 1; held_ok = 1'b1;
      while (!done0 && n < 40) begin
         @(negedge clk); n++;
         if (busy0) start0 = 1'b0;
         if (!done0 && sum0 !== 8'h30) held_ok = 1'b0;
      end
      tests_run++; if (held_ok !== 1'b1) begin tests_failed++; $display("FAIL b2b_sum_hold got %b exp 1", held_ok); end
      tests_run++; if (n !== 10) begin tests_failed++; $display("FAIL b2b_spacing got %0d exp 10", n); end
      tests_run++; if ({sum0, cout0, ovf0} !== {8'hFF, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL b2b_second got %h exp 3fc", {sum0, cout0, ovf0}); end
      start0 = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_run();
      int dn, lat, bsy; logic both;
      @(negedge clk); a0 = 8'h3C; b0 = 8'h0F; cin0 = 1'b0; sub0 = 1'b0; start0 = 1'b1;
      @(negedge clk); start0 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      tests_run++; if ({busy0, done0, sum0, cout0, ovf0} !== 12'h0) begin tests_failed++; $display("FAIL rst_mid_run got %h exp 000", {busy0, done0, sum0, cout0, ovf0}); end
      dn = 0;
      repeat (12) begin @(negedge clk); if (done0 || busy0) dn++; end
      tests_run++; if (dn !== 0) begin tests_failed++; $display("FAIL rst_no_done got %0d exp 0", dn); end
      drv8(8'h01, 8'h01, 1'b0, 1'b0, lat, bsy, both);
      tests_run++; if ({sum0, cout0, ovf0} !== {8'h02, 1'b0, 1'b0} || lat !== 9) begin tests_failed++; $display("FAIL rst_fresh_add got %h lat %0d exp 008 9", {sum0, cout0, ovf0}, lat); end
      @(negedge clk);
   endtask

   task automatic test_wide_digit();
      int lat;
      drv16(16'hFFFF, 16'h0001, 1'b1, lat);
      tests_run++; if ({sum1, cout1, ovf1} !== {16'h0001, 1'b1, 1'b0} || lat !== 5) begin tests_failed++; $display("FAIL w16d4_a got %h lat %0d exp 00006 5", {sum1, cout1, ovf1}, lat); end
      @(negedge clk);
      drv16(16'h1234, 16'h0FCD, 1'b0, lat);
      tests_run++; if ({sum1, cout1, ovf1} !== {16'h2201, 1'b0, 1'b0} || lat !== 5) begin tests_failed++; $display("FAIL w16d4_b got %h lat %0d exp 08804 5", {sum1, cout1, ovf1}, lat); end
      @(negedge clk);
   endtask

   task automatic test_single_cycle();
      int lat;
      drv88(8'h7F, 8'h01, 1'b0, lat);
      tests_run++; if ({sum2, cout2, ovf2} !== {8'h80, 1'b0, 1'b1} || lat !== 2) begin tests_failed++; $display("FAIL w8d8_a got %h lat %0d exp 201 2", {sum2, cout2, ovf2}, lat); end
      @(negedge clk);
      drv88(8'hC3, 8'h4E, 1'b1, lat);
      tests_run++; if ({sum2, cout2, ovf2} !== {8'h12, 1'b1, 1'b0} || lat !== 2) begin tests_failed++; $display("FAIL w8d8_b got %h lat %0d exp 04a 2", {sum2, cout2, ovf2}, lat); end
      @(negedge clk);
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      int lat, bsy; logic both;
      drv8(8'h05, 8'h07, 1'b1, 1'b1, lat, bsy, both);
      tests_run++; if ({sum0, cout0, ovf0} !== {8'hFE, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL sub_a got %h exp 3f8", {sum0, cout0, ovf0}); end
      @(negedge clk);
      drv8(8'h80, 8'h01, 1'b0, 1'b1, lat, bsy, both);
      tests_run++; if ({sum0, cout0, ovf0} !== {8'h7F, 1'b1, 1'b1}) begin tests_failed++; $display("FAIL sub_b got %h exp 1ff", {sum0, cout0, ovf0}); end
      @(negedge clk);
   endtask
`endif

   initial begin
      rst = 1'b1; sub0 = 1'b0;
      start0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
      start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
      start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
      test_reset();
      test_add_vectors();
      test_back_to_back();
      test_reset_mid_run();
      test_wide_digit();
      test_single_cycle();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
